vec_reg_reader: RTL and testbench

//  Read-side client of vec_reg_bank: on a host command, selects one vector register on a bank read port,

---
 rtl/vec_reg_reader_pkg.sv | 27 ++
 rtl/vec_reg_reader_if.sv | 50 +++++
 rtl/vec_reg_reader_shift_out.sv | 131 +++++++++++++
 rtl/vec_reg_reader.sv | 83 ++++++++
 tb/tb_vec_reg_reader.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_reg_reader_pkg.sv
// -----------------------------------------------------------------------------
// vec_pkg
// Shared definitions for the vector-register read-back path (vec_reg_reader).
// Holds the default geometry (BITS/N/SEL_W), the element type and the reader
// FSM state encoding, plus a helper for the element-index width.
// -----------------------------------------------------------------------------
package vec_pkg;

  localparam int BITS_DEF  = 8;
  localparam int N_DEF     = 2;
  localparam int SEL_W_DEF = 4;

  typedef logic [BITS_DEF-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    CAPTURE = 2'd2,
    STREAM  = 2'd3
  } rdr_state_t;

  // Index must be able to encode N itself (the checksum word index).
  function automatic int idx_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vec_reg_reader_if.sv
// -----------------------------------------------------------------------------
// vec_reg_reader_if
// Bundles the three handshakes of the reader: host command, bank read port and
// the outgoing element stream, plus the busy flag.
//   master : the reader (drives cmd_ready, rd_sel, rd_en, m_*, busy)
//   slave  : the environment (host command source, bank, stream sink)
// Signals:
//   cmd_valid/cmd_ready/cmd_sel   read command handshake
//   rd_sel/rd_en/rd_data          bank read port (rd_data is [N] x BITS)
//   m_valid/m_ready/m_data        element stream handshake
//   m_idx/m_last                  element index (N = checksum word), last flag
//   busy                          reader not in IDLE
// -----------------------------------------------------------------------------
interface vec_reg_reader_if
  import vec_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int N     = N_DEF,
  parameter int SEL_W = SEL_W_DEF
);

  localparam int IDX_W = idx_w(N);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [SEL_W-1:0] cmd_sel;

  logic [SEL_W-1:0] rd_sel;
  logic             rd_en;
  logic [BITS-1:0]  rd_data [N];

  logic             m_valid;
  logic             m_ready;
  logic [BITS-1:0]  m_data;
  logic [IDX_W-1:0] m_idx;
  logic             m_last;

  logic             busy;

  modport master (
    input  cmd_valid, cmd_sel, rd_data, m_ready,
    output cmd_ready, rd_sel, rd_en, m_valid, m_data, m_idx, m_last, busy
  );

  modport slave (
    output cmd_valid, cmd_sel, rd_data, m_ready,
    input  cmd_ready, rd_sel, rd_en, m_valid, m_data, m_idx, m_last, busy
  );

endinterface

// File: rtl/vec_reg_reader_shift_out.sv
// -----------------------------------------------------------------------------
// vec_shift_out
// Capture register and serialiser for vec_reg_reader. On load the N bank
// elements are latched (and, with VEC_READER_CHECKSUM_EN defined, their XOR).
// While stream_en is high the words are presented one per handshake from a
// registered output stage, so m_data/m_idx/m_last only change on a handshake.
// Optional feature macro: VEC_READER_CHECKSUM_EN (appends XOR word, idx = N).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   load                  latch rd_data into the capture vector
//   rd_data [N]           bank elements
//   stream_en             reader is in STREAM
//   m_ready               downstream accepts current word
//   m_valid/m_data/m_idx/m_last  registered stream word
//   done                  handshake on the final word this cycle
// -----------------------------------------------------------------------------
module vec_shift_out
  import vec_pkg::*;
#(
  parameter int BITS = BITS_DEF,
  parameter int N    = N_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [BITS-1:0]       rd_data [N],
  input  logic                  stream_en,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [BITS-1:0]       m_data,
  output logic [idx_w(N)-1:0]   m_idx,
  output logic                  m_last,
  output logic                  done
);

  localparam int IDX_W = idx_w(N);
`ifdef VEC_READER_CHECKSUM_EN
  localparam int NW = N + 1;
`else
  localparam int NW = N;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

  logic [BITS-1:0]  cap_p0 [N];
`ifdef VEC_READER_CHECKSUM_EN
  logic [BITS-1:0]  sum_p0;
`endif

  logic             vld_p1;
  logic [BITS-1:0]  data_p1;
  logic [IDX_W-1:0] idx_p1;
  logic             last_p1;

  logic             handshake;
  logic [IDX_W-1:0] nxt_idx;

`ifdef VEC_READER_CHECKSUM_EN
  function automatic logic [BITS-1:0] xor_fold(input logic [BITS-1:0] v [N]);
    logic [BITS-1:0] acc;
    acc = '0;
    for (int k = 0; k < N; k++) acc = acc ^ v[k];
    return acc;
  endfunction
`endif

  // Mux by comparison so an index of N never addresses past the capture array.
  function automatic logic [BITS-1:0] word_at(input logic [IDX_W-1:0] i);
    logic [BITS-1:0] w;
    w = '0;
    for (int k = 0; k < N; k++) begin
      if (i == IDX_W'(k)) w = cap_p0[k];
    end
`ifdef VEC_READER_CHECKSUM_EN
    if (i == IDX_W'(N)) w = sum_p0;
`endif
    return w;
  endfunction

  assign handshake = vld_p1 & m_ready;
  assign nxt_idx   = idx_p1 + IDX_W'(1);
  assign done      = handshake & last_p1;

  // ---- stage p0: capture vector, frozen until the next load ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) cap_p0[k] <= '0;
`ifdef VEC_READER_CHECKSUM_EN
      sum_p0 <= '0;
`endif
    end else if (load) begin
      for (int k = 0; k < N; k++) cap_p0[k] <= rd_data[k];
`ifdef VEC_READER_CHECKSUM_EN
      sum_p0 <= xor_fold(rd_data);
`endif
    end
  end

  // ---- stage p1: registered stream word ----
  // First STREAM cycle primes word 0; afterwards the word only advances on a
  // handshake, which keeps the output stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      idx_p1  <= '0;
      last_p1 <= 1'b0;
    end else if (stream_en && !vld_p1) begin
      vld_p1  <= 1'b1;
      data_p1 <= word_at('0);
      idx_p1  <= '0;
      last_p1 <= (LAST_IDX == '0);
    end else if (handshake) begin
      if (last_p1) begin
        vld_p1  <= 1'b0;
        data_p1 <= '0;
        idx_p1  <= '0;
        last_p1 <= 1'b0;
      end else begin
        data_p1 <= word_at(nxt_idx);
        idx_p1  <= nxt_idx;
        last_p1 <= (nxt_idx == LAST_IDX);
      end
    end
  end

  assign m_valid = vld_p1;
  assign m_data  = data_p1;
  assign m_idx   = idx_p1;
  assign m_last  = last_p1;

endmodule

// File: rtl/vec_reg_reader.sv
// -----------------------------------------------------------------------------
// vec_reg_reader
// Read-side client of vec_reg_bank. A host command selects one vector
// register; the reader drives the bank read port for a settle cycle and a
// capture cycle, then streams the N captured elements (index 0 first) as a
// valid/ready word stream toward the host TX framer.
// Optional feature macro: VEC_READER_CHECKSUM_EN (adds XOR checksum word).
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (aborts any transfer)
//   bus    vec_reg_reader_if.master: command, bank read port, stream, busy
// -----------------------------------------------------------------------------
module vec_reg_reader
  import vec_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int N     = N_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  vec_reg_reader_if.master   bus
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_SELECT  = SELECT;
  localparam logic [1:0] ST_CAPTURE = CAPTURE;
  localparam logic [1:0] ST_STREAM  = STREAM;

  logic [1:0]       state_r;
  logic [1:0]       state_d;
  logic [SEL_W-1:0] sel_r;
  logic             cmd_fire;
  logic             word_done;

  assign cmd_fire = bus.cmd_valid & (state_r == ST_IDLE);

  always_comb begin
    state_d = state_r;
    case (state_r)
      ST_IDLE:    if (cmd_fire) state_d = ST_SELECT;
      ST_SELECT:  state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_STREAM;
      ST_STREAM:  if (word_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      sel_r   <= '0;
    end else begin
      state_r <= state_d;
      if (cmd_fire) sel_r <= bus.cmd_sel;
    end
  end

  // Bank read is treated as combinational: SELECT lets it settle, CAPTURE
  // samples it, so rd_en covers exactly those two cycles.
  assign bus.cmd_ready = (state_r == ST_IDLE);
  assign bus.rd_sel    = sel_r;
  assign bus.rd_en     = (state_r == ST_SELECT) | (state_r == ST_CAPTURE);
  assign bus.busy      = (state_r != ST_IDLE);

  vec_shift_out #(
    .BITS (BITS),
    .N    (N)
  ) u_shift_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state_r == ST_CAPTURE),
    .rd_data   (bus.rd_data),
    .stream_en (state_r == ST_STREAM),
    .m_ready   (bus.m_ready),
    .m_valid   (bus.m_valid),
    .m_data    (bus.m_data),
    .m_idx     (bus.m_idx),
    .m_last    (bus.m_last),
    .done      (word_done)
  );

endmodule

// File: tb/tb_vec_reg_reader.sv
// -----------------------------------------------------------------------------
// tb_vec_reg_reader
// Directed bench for vec_reg_reader with a small behavioural register bank.
// Honours VEC_READER_CHECKSUM_EN the same way as the design build.
// -----------------------------------------------------------------------------
module tb_vec_reg_reader;
  import vec_pkg::*;

`ifdef VEC_READER_CHECKSUM_EN
  localparam int   NW    = 3;
  localparam logic LAST1 = 1'b0;
`else
  localparam int   NW    = 2;
  localparam logic LAST1 = 1'b1;
`endif

  logic clk;
  logic rst_n;

  vec_reg_reader_if #(.BITS(8), .N(2), .SEL_W(4)) bus ();

  vec_reg_reader #(.BITS(8), .N(2), .SEL_W(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  elem_t bank [16][2];

  always_comb begin
    for (int k = 0; k < 2; k++) bus.rd_data[k] = bank[bus.rd_sel][k];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_d [4];
  logic [1:0] got_i [4];
  logic       got_l [4];
  int         got_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue_cmd(input logic [3:0] sel, input bit keep);
    int budget = 20;
    while (!bus.cmd_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("cmd_ready_wait", 32'(bus.cmd_ready), 1);
    bus.cmd_sel   = sel;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    if (keep) bus.cmd_sel = 4'd0;
    else bus.cmd_valid = 1'b0;
  endtask

  // Records each word at the sample point before its handshake edge; stalls
  // the first word for stall0 cycles and checks it holds steady meanwhile.
  task automatic collect(input int stall0);
    int         stalls  = stall0;
    int         budget  = 40;
    bit         done    = 1'b0;
    bit         holding = 1'b0;
    logic [7:0] held_d  = '0;
    logic [1:0] held_i  = '0;
    got_n = 0;
    while (!done && budget > 0) begin
      @(posedge clk); #1;
      budget--;
      if (bus.busy) check("cmd_ready_busy", 32'(bus.cmd_ready), 0);
      if (bus.m_valid) begin
        if (stalls > 0) begin
          if (holding) begin
            check("hold_data", 32'(bus.m_data), 32'(held_d));
            check("hold_idx", 32'(bus.m_idx), 32'(held_i));
          end else begin
            held_d  = bus.m_data;
            held_i  = bus.m_idx;
            holding = 1'b1;
          end
          bus.m_ready = 1'b0;
          stalls--;
        end else begin
          if (holding) check("hold_release", 32'(bus.m_data), 32'(held_d));
          holding     = 1'b0;
          bus.m_ready = 1'b1;
          if (got_n < 4) begin
            got_d[got_n] = bus.m_data;
            got_i[got_n] = bus.m_idx;
            got_l[got_n] = bus.m_last;
          end
          got_n++;
          if (bus.m_last) done = 1'b1;
        end
      end else begin
        bus.m_ready = 1'b1;
      end
    end
    check("collect_done", 32'(done), 1);
    @(posedge clk); #1;
  endtask

  task automatic check_words(input string tag, input logic [7:0] e0, input logic [7:0] e1);
    check({tag, "_count"}, 32'(got_n), 32'(NW));
    check({tag, "_d0"}, 32'(got_d[0]), 32'(e0));
    check({tag, "_i0"}, 32'(got_i[0]), 0);
    check({tag, "_l0"}, 32'(got_l[0]), 0);
    check({tag, "_d1"}, 32'(got_d[1]), 32'(e1));
    check({tag, "_i1"}, 32'(got_i[1]), 1);
    check({tag, "_l1"}, 32'(got_l[1]), 32'(LAST1));
`ifdef VEC_READER_CHECKSUM_EN
    check({tag, "_d2"}, 32'(got_d[2]), 32'(e0 ^ e1));
    check({tag, "_i2"}, 32'(got_i[2]), 2);
    check({tag, "_l2"}, 32'(got_l[2]), 1);
`endif
    check({tag, "_idle_busy"}, 32'(bus.busy), 0);
    check({tag, "_idle_valid"}, 32'(bus.m_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_sel   = 4'd0;
    bus.m_ready   = 1'b1;
    for (int r = 0; r < 16; r++) begin
      bank[r][0] = 8'h00;
      bank[r][1] = 8'h00;
    end
    bank[0][0] = 8'h0F; bank[0][1] = 8'h3C;
    bank[1][0] = 8'hFF; bank[1][1] = 8'h7E;
    bank[2][0] = 8'h00; bank[2][1] = 8'h01;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(bus.m_valid), 0);
    check("rst_m_data", 32'(bus.m_data), 0);
    check("rst_m_idx", 32'(bus.m_idx), 0);
    check("rst_m_last", 32'(bus.m_last), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_rd_en", 32'(bus.rd_en), 0);
    check("rst_rd_sel", 32'(bus.rd_sel), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);

    // Basic read of reg2 with exact latency
    issue_cmd(4'd2, 1'b0);
    check("sel_rd_sel", 32'(bus.rd_sel), 2);
    check("sel_rd_en", 32'(bus.rd_en), 1);
    check("sel_busy", 32'(bus.busy), 1);
    check("sel_cmd_ready", 32'(bus.cmd_ready), 0);
    check("sel_m_valid", 32'(bus.m_valid), 0);
    @(posedge clk); #1;
    check("cap_rd_en", 32'(bus.rd_en), 1);
    check("cap_rd_sel", 32'(bus.rd_sel), 2);
    check("cap_m_valid", 32'(bus.m_valid), 0);
    @(posedge clk); #1;
    check("t2_m_valid", 32'(bus.m_valid), 0);
    check("t2_rd_en", 32'(bus.rd_en), 0);
    @(posedge clk); #1;
    check("w0_valid", 32'(bus.m_valid), 1);
    check("w0_data", 32'(bus.m_data), 8'h00);
    check("w0_idx", 32'(bus.m_idx), 0);
    check("w0_last", 32'(bus.m_last), 0);
    @(posedge clk); #1;
    check("w1_valid", 32'(bus.m_valid), 1);
    check("w1_data", 32'(bus.m_data), 8'h01);
    check("w1_idx", 32'(bus.m_idx), 1);
    check("w1_last", 32'(bus.m_last), 32'(LAST1));
`ifdef VEC_READER_CHECKSUM_EN
    @(posedge clk); #1;
    check("w2_valid", 32'(bus.m_valid), 1);
    check("w2_data", 32'(bus.m_data), 8'h01);
    check("w2_idx", 32'(bus.m_idx), 2);
    check("w2_last", 32'(bus.m_last), 1);
`endif
    @(posedge clk); #1;
    check("end_valid", 32'(bus.m_valid), 0);
    check("end_busy", 32'(bus.busy), 0);
    check("end_cmd_ready", 32'(bus.cmd_ready), 1);

    // Backpressure on word 0 of reg1
    issue_cmd(4'd1, 1'b0);
    collect(4);
    check_words("bp", 8'hFF, 8'h7E);

    // Command held during a transfer: ignored until IDLE, then reg0 read
    issue_cmd(4'd1, 1'b1);
    collect(0);
    check_words("blk_a", 8'hFF, 8'h7E);
    check("blk_cmd_ready", 32'(bus.cmd_ready), 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("blk_busy", 32'(bus.busy), 1);
    check("blk_rd_sel", 32'(bus.rd_sel), 0);
    collect(0);
    check_words("blk_b", 8'h0F, 8'h3C);

    // Bank rewritten after capture: stream keeps captured values
    issue_cmd(4'd2, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bank[2][0] = 8'hAA;
    bank[2][1] = 8'hAA;
    collect(0);
    check_words("iso", 8'h00, 8'h01);
    bank[2][0] = 8'h00;
    bank[2][1] = 8'h01;

    // Reset in the middle of STREAM
    bus.m_ready = 1'b0;
    issue_cmd(4'd1, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid_valid", 32'(bus.m_valid), 1);
    check("mid_data", 32'(bus.m_data), 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_m_valid", 32'(bus.m_valid), 0);
    check("arst_m_data", 32'(bus.m_data), 0);
    check("arst_m_idx", 32'(bus.m_idx), 0);
    check("arst_m_last", 32'(bus.m_last), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_rd_en", 32'(bus.rd_en), 0);
    check("arst_rd_sel", 32'(bus.rd_sel), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arel_cmd_ready", 32'(bus.cmd_ready), 1);
    check("arel_m_valid", 32'(bus.m_valid), 0);
    bus.m_ready = 1'b1;
    issue_cmd(4'd0, 1'b0);
    collect(0);
    check_words("rec", 8'h0F, 8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
